// File: rtl/debounce_toggle_array_if.sv
// ---------------------------------------------------------------------------
// debounce_toggle_array_if
// Bundles the per-channel switch pins, clear requests and conditioned outputs
// of debounce_toggle_array.
//   i_Switch     : raw switch pins, 1 = pressed
//   i_Clear      : per-channel synchronous clear of the toggle state
//   o_Switch     : debounced level
//   o_Press      : one-cycle pulse on debounced 0->1
//   o_Release    : one-cycle pulse on debounced 1->0
//   o_Long_Press : one-cycle pulse when a press reaches the long-press limit
//   o_Toggle     : toggle state (LED drive)
// master = pin/clear source side, slave = conditioner side.
// ---------------------------------------------------------------------------
interface debounce_toggle_array_if #(
   parameter int unsigned NUM_CH = 4
);
   logic [NUM_CH-1:0] i_Switch;
   logic [NUM_CH-1:0] i_Clear;
   logic [NUM_CH-1:0] o_Switch;
   logic [NUM_CH-1:0] o_Press;
   logic [NUM_CH-1:0] o_Release;
   logic [NUM_CH-1:0] o_Long_Press;
   logic [NUM_CH-1:0] o_Toggle;

   modport master (
      output i_Switch,
      output i_Clear,
      input  o_Switch,
      input  o_Press,
      input  o_Release,
      input  o_Long_Press,
      input  o_Toggle
   );

   modport slave (
      input  i_Switch,
      input  i_Clear,
      output o_Switch,
      output o_Press,
      output o_Release,
      output o_Long_Press,
      output o_Toggle
   );
endinterface

// File: rtl/debounce_toggle_array.sv
// ---------------------------------------------------------------------------
// debounce_toggle_array
// Multi-channel push-button conditioner. Each channel: 2-FF synchroniser,
// stability-counter debounce, registered press/release pulses, long-press
// pulse and a toggle state.
// Ports:
//   i_Clk   : clock, all registers on rising edge
//   i_Reset : synchronous active-high reset
//   sw_if   : slave modport carrying pins, clears and all conditioned outputs
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module debounce_toggle_array #(
   parameter int unsigned NUM_CH           = 4,
   parameter int unsigned DEBOUNCE_LIMIT   = 250000,
   parameter int unsigned LONG_PRESS_LIMIT = 25000000,
   parameter int unsigned TOGGLE_ON_PRESS  = 0
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   debounce_toggle_array_if.slave  sw_if
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int unsigned DB_LAST = DEBOUNCE_LIMIT - 1;

   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;
   logic [NUM_CH-1:0] sw_q,    sw_d;
   logic [NUM_CH-1:0] press_q, press_d;
   logic [NUM_CH-1:0] rel_q,   rel_d;
   logic [NUM_CH-1:0] lp_q,    lp_d;
   logic [NUM_CH-1:0] tog_q,   tog_d;
   logic [NUM_CH-1:0] tog_event;
   logic [DB_W-1:0]   db_cnt_q [NUM_CH];
   logic [DB_W-1:0]   db_cnt_d [NUM_CH];

   // Debounce: count cycles the synchronised pin disagrees with the accepted
   // level; accept the new level on the cycle the count would hit the limit.
   always_comb begin
      sw_d = sw_q;
      for (int c = 0; c < NUM_CH; c++) begin
         db_cnt_d[c] = '0;
         if (sync2_q[c] != sw_q[c]) begin
            if (db_cnt_q[c] == DB_W'(DB_LAST)) begin
               sw_d[c] = sync2_q[c];
            end else begin
               db_cnt_d[c] = db_cnt_q[c] + DB_W'(1);
            end
         end
      end
   end

   // Edge pulses are derived from the next level so they line up with o_Switch.
   always_comb begin
      press_d   = sw_d & ~sw_q;
      rel_d     = ~sw_d & sw_q;
      tog_event = (TOGGLE_ON_PRESS != 0) ? press_d : rel_d;
      // Clear dominates a coincident toggle event.
      tog_d     = (tog_q ^ tog_event) & ~sw_if.i_Clear;
   end

   // Long-press detection; the counter only advances while the level stays
   // high across an edge and saturates so each press pulses at most once.
   generate
      if (LONG_PRESS_LIMIT != 0) begin : g_long
         localparam int unsigned LP_W    = $clog2(LONG_PRESS_LIMIT + 1);
         localparam int unsigned LP_LAST = LONG_PRESS_LIMIT - 1;

         logic [LP_W-1:0] lp_cnt_q [NUM_CH];
         logic [LP_W-1:0] lp_cnt_d [NUM_CH];

         always_comb begin
            lp_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
               lp_cnt_d[c] = '0;
               if (sw_d[c] && sw_q[c]) begin
                  if (lp_cnt_q[c] == LP_W'(LONG_PRESS_LIMIT)) begin
                     lp_cnt_d[c] = lp_cnt_q[c];
                  end else begin
                     lp_cnt_d[c] = lp_cnt_q[c] + LP_W'(1);
                  end
                  lp_d[c] = (lp_cnt_q[c] == LP_W'(LP_LAST));
               end
            end
         end

         always_ff @(posedge i_Clk) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (i_Reset) begin
                  lp_cnt_q[c] <= '0;
               end else begin
                  lp_cnt_q[c] <= lp_cnt_d[c];
               end
            end
         end
      end else begin : g_no_long
         always_comb begin
            lp_d = '0;
         end
      end
   endgenerate

   // State registers.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sw_q    <= '0;
         press_q <= '0;
         rel_q   <= '0;
         lp_q    <= '0;
         tog_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            db_cnt_q[c] <= '0;
         end
      end else begin
         sync1_q <= sw_if.i_Switch;
         sync2_q <= sync1_q;
         sw_q    <= sw_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         lp_q    <= lp_d;
         tog_q   <= tog_d;
         for (int c = 0; c < NUM_CH; c++) begin
            db_cnt_q[c] <= db_cnt_d[c];
         end
      end
   end

   assign sw_if.o_Switch     = sw_q;
   assign sw_if.o_Press      = press_q;
   assign sw_if.o_Release    = rel_q;
   assign sw_if.o_Long_Press = lp_q;
   assign sw_if.o_Toggle     = tog_q;

endmodule

// File: tb/tb_debounce_toggle_array.sv
// ---------------------------------------------------------------------------
// tb_debounce_toggle_array
// Two instances (release-toggle and press-toggle) share the same stimulus.
// A look-back reference model predicts every output after every edge.
// ---------------------------------------------------------------------------
module tb_debounce_toggle_array;

   localparam int NCH  = 4;
   localparam int DL   = 4;
   localparam int LPL  = 10;
   localparam int MAXC = 8192;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   debounce_toggle_array_if #(.NUM_CH(NCH)) sif0 ();
   debounce_toggle_array_if #(.NUM_CH(NCH)) sif1 ();

   debounce_toggle_array #(
      .NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .LONG_PRESS_LIMIT(LPL), .TOGGLE_ON_PRESS(0)
   ) dut0 (.i_Clk(clk), .i_Reset(rst), .sw_if(sif0.slave));

   debounce_toggle_array #(
      .NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .LONG_PRESS_LIMIT(LPL), .TOGGLE_ON_PRESS(1)
   ) dut1 (.i_Clk(clk), .i_Reset(rst), .sw_if(sif1.slave));

   int tests = 0;
   int fails = 0;

   // Reference model state: synchronised-pin history per edge, edge of last
   // level change (or reset) per channel, edge of last rise per channel.
   logic [NCH-1:0] s_h [MAXC];
   int             mark [NCH];
   int             rise [NCH];
   int             t = 0;
   logic [NCH-1:0] p_prev = '0;
   logic           rst_prev = 1'b1;
   bit             valid = 0;
   logic [NCH-1:0] m_o = '0, m_press = '0, m_rel = '0, m_lp = '0;
   logic [NCH-1:0] m_tog0 = '0, m_tog1 = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s edge=%0d got=%h exp=%h", tag, t, act, exp);
      end
   endtask

   // Level flips at edge t when the synchronised pin showed the opposite
   // level on each of the previous DL edges, none earlier than the last
   // change/reset. Pulses and toggles follow from the level sequence.
   task automatic model_step(input logic [NCH-1:0] pin, input logic [NCH-1:0] clr,
                             input logic rst_v);
      logic [NCH-1:0] old;
      bit ok;
      if (rst_v) begin
         m_o = '0; m_press = '0; m_rel = '0; m_lp = '0; m_tog0 = '0; m_tog1 = '0;
         s_h[t] = '0;
         for (int c = 0; c < NCH; c++) mark[c] = t;
      end else begin
         old = m_o;
         for (int c = 0; c < NCH; c++) begin
            ok = 1;
            for (int j = 1; j <= DL; j++) begin
               if (t - j < mark[c]) ok = 0;
               else if (s_h[t-j][c] == old[c]) ok = 0;
            end
            if (ok) begin
               m_o[c]  = ~old[c];
               mark[c] = t;
               if (m_o[c]) rise[c] = t;
            end
         end
         m_press = m_o & ~old;
         m_rel   = ~m_o & old;
         for (int c = 0; c < NCH; c++) m_lp[c] = m_o[c] && ((t - rise[c]) == LPL);
         m_tog0 = (m_tog0 ^ m_rel) & ~clr;
         m_tog1 = (m_tog1 ^ m_press) & ~clr;
         s_h[t] = rst_prev ? '0 : p_prev;
      end
      p_prev   = pin;
      rst_prev = rst_v;
      t++;
   endtask

   task automatic compare_all();
      check("sw0",    32'(sif0.o_Switch),     32'(m_o));
      check("press0", 32'(sif0.o_Press),      32'(m_press));
      check("rel0",   32'(sif0.o_Release),    32'(m_rel));
      check("lp0",    32'(sif0.o_Long_Press), 32'(m_lp));
      check("tog0",   32'(sif0.o_Toggle),     32'(m_tog0));
      check("sw1",    32'(sif1.o_Switch),     32'(m_o));
      check("press1", 32'(sif1.o_Press),      32'(m_press));
      check("tog1",   32'(sif1.o_Toggle),     32'(m_tog1));
   endtask

   // One edge: check state from the previous edge, drive inputs, advance.
   task automatic tick(input logic [NCH-1:0] sw, input logic [NCH-1:0] clr, input logic rst_v);
      if (valid) compare_all();
      sif0.i_Switch = sw;  sif1.i_Switch = sw;
      sif0.i_Clear  = clr; sif1.i_Clear  = clr;
      rst = rst_v;
      model_step(sw, clr, rst_v);
      valid = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle(input logic [NCH-1:0] clr);
      for (int i = 0; i < 10; i++) tick('0, clr, 1'b0);
   endtask

   initial begin
      int lp_count;
      logic [NCH-1:0] sw_r, clr_r;
      logic rst_r;
      int flip_pct;

      rst = 1'b1;
      sif0.i_Switch = '0; sif1.i_Switch = '0;
      sif0.i_Clear  = '0; sif1.i_Clear  = '0;
      @(negedge clk);

      // Reset with all pins held: outputs 0, then fresh press 6 edges later.
      for (int i = 0; i < 3; i++) tick(4'hF, '0, 1'b1);
      check("rst_sw",  32'(sif0.o_Switch), 32'h0);
      check("rst_tog", 32'(sif0.o_Toggle), 32'h0);
      for (int i = 1; i <= 7; i++) begin
         tick(4'hF, '0, 1'b0);
         if (i == 5) check("rst_sw5", 32'(sif0.o_Switch), 32'h0);
         if (i == 6) begin
            check("rst_sw6",    32'(sif0.o_Switch), 32'hF);
            check("rst_press6", 32'(sif0.o_Press),  32'hF);
         end
         if (i == 7) begin
            check("rst_press7", 32'(sif0.o_Press),  32'h0);
            check("rst_tog7",   32'(sif0.o_Toggle), 32'h0);
         end
      end
      settle('1);

      // Bounce rejection on ch0.
      begin
         logic [7:0] bseq;
         bseq = 8'b0111_0111;
         for (int i = 0; i < 8; i++) tick({3'b000, bseq[i]}, '0, 1'b0);
         for (int i = 0; i < 12; i++) tick(4'b0001, '0, 1'b0);
         settle('0);
      end

      // Toggle on release, ch2, twice.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 12; i++) tick(4'b0100, '0, 1'b0);
         settle('0);
         check("tog_ch2", 32'(sif0.o_Toggle[2]), (r == 0) ? 32'h1 : 32'h0);
      end

      // Long press on ch1.
      lp_count = 0;
      for (int i = 0; i < 30; i++) begin
         tick(4'b0010, '0, 1'b0);
         lp_count += 32'(sif0.o_Long_Press[1]);
      end
      check("lp_count", 32'(lp_count), 32'h1);
      settle('0);
      check("lp_tog1", 32'(sif0.o_Toggle[1]), 32'h1);

      // Clear on the release edge of ch1, then of ch2 (where it would toggle to 1).
      for (int i = 0; i < 12; i++) tick(4'b0010, '0, 1'b0);
      for (int i = 0; i < 10; i++) tick('0, (i == 5) ? 4'b0010 : 4'b0000, 1'b0);
      check("clr_tog1", 32'(sif0.o_Toggle[1]), 32'h0);
      for (int i = 0; i < 12; i++) tick(4'b0100, '0, 1'b0);
      for (int i = 0; i < 10; i++) tick('0, (i == 5) ? 4'b0100 : 4'b0000, 1'b0);
      check("clr_tog2", 32'(sif0.o_Toggle[2]), 32'h0);

      // Press-mode instance, all channels rise together.
      settle('1);
      for (int i = 0; i < 8; i++) begin
         tick(4'hF, '0, 1'b0);
         if (i == 4) check("pm_press4", 32'(sif1.o_Press), 32'h0);
         if (i == 5) begin
            check("pm_press5", 32'(sif1.o_Press),  32'hF);
            check("pm_tog5",   32'(sif1.o_Toggle), 32'hF);
         end
      end
      settle('0);

      // Reset mid-debounce on ch3.
      tick(4'h8, '0, 1'b0);
      tick(4'h8, '0, 1'b0);
      tick(4'h8, '0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick(4'h8, '0, 1'b0);
         if (i < 6)  check("rmid_press", 32'(sif0.o_Press), 32'h0);
         if (i == 6) check("rmid_press6", 32'(sif0.o_Press), 32'h8);
      end
      settle('0);

      // Random: bouncy phase, then long-hold phase with occasional clear/reset.
      sw_r = '0;
      for (int ph = 0; ph < 2; ph++) begin
         flip_pct = (ph == 0) ? 20 : 3;
         for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) begin
               if ($urandom_range(0, 99) < flip_pct) sw_r[c] = ~sw_r[c];
               clr_r[c] = ($urandom_range(0, 99) < 3);
            end
            rst_r = ($urandom_range(0, 999) < 4);
            tick(sw_r, clr_r, rst_r);
         end
      end
      compare_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/debounce_toggle_array.md
# debounce_toggle_array

Parametrised multi-channel switch conditioner for the board's push-button inputs. Each channel synchronises a raw switch pin, debounces it with a stability counter, and produces a clean level, one-cycle press/release pulses, a long-press pulse and a toggle state for LED control. It sits directly behind the top-level switch pins and replaces per-switch debounce instances plus hand-written toggle logic in project tops.

## Interface
- NUM_CH, 4: number of independent switch channels (≥1).
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles required to accept a new level (≥1; 10 ms at 25 MHz).
- LONG_PRESS_LIMIT, 25000000: cycles the debounced level must stay 1 before o_Long_Press fires; 0 disables the long-press function.
- TOGGLE_ON_PRESS, 0: 0 = toggle on the debounced release edge, 1 = toggle on the debounced press edge.

Ports:
- i_Clk  input  1  system clock. One clock; every register is on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Switch  input  NUM_CH  raw, asynchronous switch pins, 1 = pressed.
- i_Clear  input  NUM_CH  per-channel synchronous clear of the toggle state.
- o_Switch  output  NUM_CH  debounced level.
- o_Press  output  NUM_CH  one-cycle pulse on the debounced 0→1 edge.
- o_Release  output  NUM_CH  one-cycle pulse on the debounced 1→0 edge.
- o_Long_Press  output  NUM_CH  one-cycle pulse when a press reaches LONG_PRESS_LIMIT.
- o_Toggle  output  NUM_CH  toggle state, drives LEDs directly.

## Operation
- Channels are fully independent. Per channel: 2-FF synchroniser, then stability counter, then debounced register, then edge/toggle/long-press logic.
- Stability counter width is $clog2(DEBOUNCE_LIMIT+1).
  - If the synchronised input equals o_Switch, the counter is 0.
  - If it differs, the counter increments by 1 each cycle.
  - On the cycle the counter would reach DEBOUNCE_LIMIT, o_Switch takes the new value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_LIMIT cycles restarts the count and leaves o_Switch unchanged.
- o_Press and o_Release are registered. They assert on the same edge that o_Switch changes and last exactly one cycle.
- Toggle update:
  - o_Toggle inverts on o_Release when TOGGLE_ON_PRESS=0, or on o_Press when TOGGLE_ON_PRESS=1.
  - i_Clear forces the channel's o_Toggle to 0 on the next edge and wins over a simultaneous toggle event.
- Long-press counter:
  - Width is $clog2(LONG_PRESS_LIMIT+1).
  - Counts while o_Switch=1 and is 0 while o_Switch=0.
  - When it reaches LONG_PRESS_LIMIT, o_Long_Press pulses for one cycle. The counter then saturates, so there is at most one pulse per press.
  - Release clears the counter. A long press still produces its normal release/toggle event.
- Reset (i_Reset=1 on an edge):
  - Synchroniser, both counters, o_Switch, o_Press, o_Release, o_Long_Press and o_Toggle all go to 0.
  - Reset mid-count discards partial counts.
  - A switch held through reset is re-debounced from 0 and yields a fresh o_Press DEBOUNCE_LIMIT+2 cycles after reset release.

## Timing
- A pin change stable from edge N reaches the synchroniser output at edge N+2.
- o_Switch, o_Press and o_Release update at edge N+2+DEBOUNCE_LIMIT. o_Toggle updates on the same edge.
- o_Long_Press pulses LONG_PRESS_LIMIT edges after o_Switch rises, i.e. on the cycle o_Switch has been 1 for LONG_PRESS_LIMIT edges.
- No combinational path from any input to any output. All outputs are registered.
- i_Clear takes effect one edge after it is sampled high. Holding it high keeps o_Toggle at 0.

## Test plan
Use NUM_CH=4, DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10, TOGGLE_ON_PRESS=0 unless stated.
- Reset: hold i_Reset 3 cycles with i_Switch=4'b1111 → all outputs 0. After release, o_Switch=4'b1111 and o_Press=4'b1111 pulse exactly 6 cycles later; o_Toggle stays 0.
- Bounce rejection: ch0 sequence 1,1,1,0,1,1,1,0 then steady 1 → o_Switch[0] rises 6 cycles after the final 0→1. There is exactly one o_Press[0] pulse and no o_Release[0].
- Toggle on release: ch2 press for 8 cycles, then release → o_Toggle[2] goes 0→1 on the o_Release[2] edge. A second press/release returns it to 0. Other channels are unchanged.
- Long press and clear:
  - Hold ch1 for 30 cycles → a single o_Long_Press[1] pulse exactly 10 cycles after o_Switch[1] rises, then release toggles o_Toggle[1] to 1.
  - Then assert i_Clear[1] on the same cycle as the next o_Release[1] → o_Toggle[1]=0.
- Press mode with simultaneous channels: TOGGLE_ON_PRESS=1, all four pins rise on the same edge → o_Press=4'b1111 and o_Toggle=4'b1111 on the same edge, 6 cycles later.
- Reset mid-debounce: ch3 rises, i_Reset pulses 2 cycles later → no o_Press[3] until 6 cycles after reset release.
